// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: rebuilds VGA pixel coordinates from hsync/vsync edges and checks line/frame timing.
// Build macro VGA_SYNC_MON_ERRCNT_EN enables the saturating err_count; otherwise err_count reads 8'h00.
module vga_sync_monitor #(
   parameter int H_TOTAL      = 800,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_LEN   = 96,
   parameter int V_TOTAL      = 525,
   parameter int V_SYNC_START = 490,
   parameter int V_SYNC_LEN   = 2,
   parameter int LOCK_FRAMES  = 2,
   parameter int H_VISIBLE    = 640,
   parameter int V_VISIBLE    = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hsync,
   input  logic       vsync,
   output logic       locked,
   output logic [9:0] rx_hcount,
   output logic [9:0] rx_vcount,
   output logic       rx_visible,
   output logic       frame_start,
   output logic       line_err,
   output logic       frame_err,
   output logic [7:0] err_count
);

   localparam logic [9:0] H_TOT_W  = 10'(H_TOTAL);
   localparam logic [9:0] H_LAST_W = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_SS_W   = 10'(H_SYNC_START);
   localparam logic [9:0] H_SL_W   = 10'(H_SYNC_LEN);
   localparam logic [9:0] V_TOT_W  = 10'(V_TOTAL);
   localparam logic [9:0] V_LAST_W = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_SS_W   = 10'(V_SYNC_START);
   localparam logic [9:0] V_SL_W   = 10'(V_SYNC_LEN);
   localparam logic [9:0] H_VIS_W  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_W  = 10'(V_VISIBLE);
   localparam logic [7:0] LOCK_W   = 8'(LOCK_FRAMES);
   localparam logic [9:0] CNT_MAX  = 10'h3FF;

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_TRACK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic       hs_q_r, hs_d_r, vs_q_r, vs_d_r;
   logic       h_fall_s, h_rise_s, v_fall_s, v_rise_s, h_wrap_s;
   logic [9:0] hcnt_nxt_s, vcnt_nxt_s;
   logic [9:0] line_len_r, hs_width_r, frame_len_r, vs_width_r;
   logic [9:0] frame_len_inc_s, vs_width_inc_s;
   logic       h_armed_r, hw_valid_r, v_armed_r, vw_valid_r;
   logic       line_err_s, frame_err_s;
   logic [1:0] state_r;
   logic [7:0] good_cnt_r;
   logic       dirty_r;

   // Edge decode, next coordinates and error detection
   always_comb begin
      h_fall_s = hs_d_r & ~hs_q_r;
      h_rise_s = ~hs_d_r & hs_q_r;
      v_fall_s = vs_d_r & ~vs_q_r;
      v_rise_s = ~vs_d_r & vs_q_r;
      h_wrap_s = ~h_fall_s & (rx_hcount == H_LAST_W);

      if (h_fall_s) begin
         hcnt_nxt_s = H_SS_W;
      end else if (rx_hcount == H_LAST_W) begin
         hcnt_nxt_s = 10'd0;
      end else begin
         hcnt_nxt_s = rx_hcount + 10'd1;
      end

      if (v_fall_s) begin
         vcnt_nxt_s = V_SS_W;
      end else if (h_wrap_s) begin
         vcnt_nxt_s = (rx_vcount == V_LAST_W) ? 10'd0 : rx_vcount + 10'd1;
      end else begin
         vcnt_nxt_s = rx_vcount;
      end

      // A fall coinciding with the closing vsync fall belongs to the frame being measured
      frame_len_inc_s = (h_fall_s && frame_len_r != CNT_MAX) ? frame_len_r + 10'd1 : frame_len_r;
      vs_width_inc_s  = (h_fall_s && !vs_q_r && vs_width_r != CNT_MAX) ? vs_width_r + 10'd1 : vs_width_r;

      line_err_s  = (h_fall_s & h_armed_r & (line_len_r != H_TOT_W)) |
                    (h_rise_s & hw_valid_r & (hs_width_r != H_SL_W));
      frame_err_s = (v_fall_s & v_armed_r & (frame_len_inc_s != V_TOT_W)) |
                    (v_rise_s & vw_valid_r & (vs_width_r != V_SL_W));
   end

   // Sync input pipeline, coordinate counters and registered status pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q_r      <= 1'b1;
         hs_d_r      <= 1'b1;
         vs_q_r      <= 1'b1;
         vs_d_r      <= 1'b1;
         rx_hcount   <= 10'd0;
         rx_vcount   <= 10'd0;
         rx_visible  <= 1'b0;
         frame_start <= 1'b0;
         line_err    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         hs_q_r      <= hsync;
         hs_d_r      <= hs_q_r;
         vs_q_r      <= vsync;
         vs_d_r      <= vs_q_r;
         rx_hcount   <= hcnt_nxt_s;
         rx_vcount   <= vcnt_nxt_s;
         rx_visible  <= (hcnt_nxt_s < H_VIS_W) && (vcnt_nxt_s < V_VIS_W);
         frame_start <= (hcnt_nxt_s == 10'd0) && (vcnt_nxt_s == 10'd0);
         line_err    <= line_err_s;
         frame_err   <= frame_err_s;
      end
   end

   // Length and width measurement; a pulse is only judged if a real fall preceded it
   always_ff @(posedge clk) begin
      if (reset) begin
         line_len_r  <= 10'd0;
         hs_width_r  <= 10'd0;
         frame_len_r <= 10'd0;
         vs_width_r  <= 10'd0;
         h_armed_r   <= 1'b0;
         hw_valid_r  <= 1'b0;
         v_armed_r   <= 1'b0;
         vw_valid_r  <= 1'b0;
      end else begin
         if (h_fall_s) begin
            line_len_r <= 10'd1;
            hs_width_r <= 10'd1;
            h_armed_r  <= 1'b1;
            hw_valid_r <= h_armed_r;
         end else begin
            if (line_len_r != CNT_MAX) line_len_r <= line_len_r + 10'd1;
            if (!hs_q_r && hs_width_r != CNT_MAX) hs_width_r <= hs_width_r + 10'd1;
         end
         if (v_fall_s) begin
            frame_len_r <= 10'd0;
            vs_width_r  <= {9'd0, h_fall_s};
            v_armed_r   <= 1'b1;
            vw_valid_r  <= v_armed_r;
         end else begin
            frame_len_r <= frame_len_inc_s;
            vs_width_r  <= vs_width_inc_s;
         end
      end
   end

   // Lock state machine: SEARCH -> TRACK -> LOCKED after LOCK_FRAMES clean frames
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_SEARCH;
         good_cnt_r <= 8'd0;
         dirty_r    <= 1'b0;
         locked     <= 1'b0;
      end else begin
         locked <= (state_r == ST_LOCKED);
         case (state_r)
            ST_SEARCH: begin
               if (v_fall_s) begin
                  state_r    <= ST_TRACK;
                  good_cnt_r <= 8'd0;
                  dirty_r    <= 1'b0;
               end
            end
            ST_TRACK: begin
               if (v_fall_s) begin
                  dirty_r <= 1'b0;
                  if (line_err_s || frame_err_s || dirty_r) begin
                     good_cnt_r <= 8'd0;
                  end else if (good_cnt_r + 8'd1 >= LOCK_W) begin
                     state_r    <= ST_LOCKED;
                     good_cnt_r <= 8'd0;
                  end else begin
                     good_cnt_r <= good_cnt_r + 8'd1;
                  end
               end else if (line_err_s || frame_err_s) begin
                  good_cnt_r <= 8'd0;
                  dirty_r    <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (line_err_s || frame_err_s) state_r <= ST_SEARCH;
            end
            default: state_r <= ST_SEARCH;
         endcase
      end
   end

`ifdef VGA_SYNC_MON_ERRCNT_EN
   logic [8:0] err_sum_s;

   // Saturating sum of error pulses, two per cycle when both fire
   always_comb begin
      err_sum_s = {1'b0, err_count} + {8'd0, line_err_s} + {8'd0, frame_err_s};
   end

   // Error counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= 8'd0;
      end else begin
         err_count <= (err_sum_s > 9'd255) ? 8'hFF : err_sum_s[7:0];
      end
   end
`else
   assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced timing (20x12) so whole frames stay short.
module tb_vga_sync_monitor;

   localparam int HT  = 20;
   localparam int HSS = 14;
   localparam int HSL = 3;
   localparam int VT  = 12;
   localparam int VSS = 9;
   localparam int VSL = 2;
   localparam int HV  = 16;
   localparam int VV  = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hsync = 1'b1;
   logic       vsync = 1'b1;
   logic       locked, rx_visible, frame_start, line_err, frame_err;
   logic [9:0] rx_hcount, rx_vcount;
   logic [7:0] err_count;

   int n_chk = 0, n_err = 0;
   int cyc = 0, n_line = 0, n_frame = 0, n_fs = 0, fs_bad = 0, fs_last = 0, fs_period = 0;
   int coord_bad = 0, last_err_cyc = 0, drop_cyc = -1, exp_err = 0;
   int h_d1 = 0, h_d2 = 0, v_d1 = 0, v_d2 = 0;
   bit chk_coord = 1'b0, prev_locked = 1'b0;

   vga_sync_monitor #(
      .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
      .LOCK_FRAMES(2), .H_VISIBLE(HV), .V_VISIBLE(VV)
   ) dut (
      .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
      .locked(locked), .rx_hcount(rx_hcount), .rx_vcount(rx_vcount),
      .rx_visible(rx_visible), .frame_start(frame_start),
      .line_err(line_err), .frame_err(frame_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_errcnt(input int e);
      logic [7:0] r;
      r = (e > 255) ? 8'hFF : 8'(e);
`ifndef VGA_SYNC_MON_ERRCNT_EN
      r = 8'h00;
`endif
      return r;
   endfunction

   // One clock: observe outputs 1 ns after the edge, then drive the next source position
   task automatic step(input int h, input int v, input logic hs, input logic vs);
      @(posedge clk);
      #1;
      cyc++;
      if (line_err) begin n_line++; last_err_cyc = cyc; end
      if (frame_err) n_frame++;
      if (prev_locked && !locked) drop_cyc = cyc;
      prev_locked = locked;
      if (frame_start) begin
         n_fs++;
         fs_period = cyc - fs_last;
         fs_last = cyc;
         if (rx_hcount != 10'd0 || rx_vcount != 10'd0) fs_bad++;
      end
      if (chk_coord) begin
         if (rx_hcount !== 10'(h_d2) || rx_vcount !== 10'(v_d2) ||
             rx_visible !== (h_d2 < HV && v_d2 < VV)) coord_bad++;
      end
      h_d2 = h_d1; h_d1 = h; v_d2 = v_d1; v_d1 = v;
      hsync = hs;
      vsync = vs;
   endtask

   task automatic drive_line(input int v, input int len, input int sl, input bit vs_low);
      for (int h = 0; h < len; h++)
         step(h, v, (h >= HSS && h < HSS + sl) ? 1'b0 : 1'b1, vs_low ? 1'b0 : 1'b1);
   endtask

   task automatic drive_frame(input int v0, input int v1, input int vs_lines,
                              input int bad_line, input int bad_len, input int bad_sl);
      for (int v = v0; v < v1; v++)
         drive_line(v, (v == bad_line) ? bad_len : HT, (v == bad_line) ? bad_sl : HSL,
                    (v >= VSS && v < VSS + vs_lines));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(0, 0, 1'b1, 1'b1);
      step(0, 0, 1'b1, 1'b1);
      n_chk++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %0b want 0", locked); end
      n_chk++; if (rx_hcount !== 10'd0 || rx_vcount !== 10'd0) begin
         n_err++; $display("FAIL reset_coords: got %0d,%0d want 0,0", rx_hcount, rx_vcount); end
      n_chk++; if ({line_err, frame_err, frame_start, rx_visible} !== 4'b0000) begin
         n_err++; $display("FAIL reset_pulses: got %b want 0000", {line_err, frame_err, frame_start, rx_visible}); end
      n_chk++; if (err_count !== 8'h00) begin n_err++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
      reset = 1'b0;
   endtask

   task automatic test_nominal_lock();
      drive_frame(0, VT, VSL, -1, HT, HSL);
      drive_frame(0, VT, VSL, -1, HT, HSL);
      n_chk++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_early: got %0b want 0", locked); end
      chk_coord = 1'b1;
      drive_frame(0, VT, VSL, -1, HT, HSL);
      n_chk++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_third_vfall: got %0b want 1", locked); end
      drive_frame(0, VT, VSL, -1, HT, HSL);
      n_chk++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_hold: got %0b want 1", locked); end
      n_chk++; if (n_line != 0 || n_frame != 0) begin
         n_err++; $display("FAIL nominal_errs: got line=%0d frame=%0d want 0,0", n_line, n_frame); end
      n_chk++; if (err_count !== exp_errcnt(exp_err)) begin
         n_err++; $display("FAIL nominal_errcnt: got %0d want %0d", err_count, exp_errcnt(exp_err)); end
      n_chk++; if (coord_bad != 0) begin n_err++; $display("FAIL coord_delay2: got %0d bad cycles want 0", coord_bad); end
   endtask

   task automatic test_frame_start();
      n_fs = 0;
      drive_frame(0, VT, VSL, -1, HT, HSL);
      drive_frame(0, VT, VSL, -1, HT, HSL);
      chk_coord = 1'b0;
      n_chk++; if (n_fs != 2) begin n_err++; $display("FAIL fs_count: got %0d want 2", n_fs); end
      n_chk++; if (fs_period != HT * VT) begin n_err++; $display("FAIL fs_period: got %0d want %0d", fs_period, HT * VT); end
      n_chk++; if (fs_bad != 0) begin n_err++; $display("FAIL fs_coords: got %0d bad pulses want 0", fs_bad); end
   endtask

   task automatic test_short_line();
      int base_l, base_f;
      base_l = n_line; base_f = n_frame; drop_cyc = -1;
      drive_frame(0, VT, VSL, 3, HT - 1, HSL);
      exp_err += 1;
      n_chk++; if (n_line != base_l + 1 || n_frame != base_f) begin
         n_err++; $display("FAIL short_line_err: got line+%0d frame+%0d want 1,0", n_line - base_l, n_frame - base_f); end
      n_chk++; if (drop_cyc != last_err_cyc + 1) begin
         n_err++; $display("FAIL short_line_unlock: got drop at %0d want %0d", drop_cyc, last_err_cyc + 1); end
      n_chk++; if (err_count !== exp_errcnt(exp_err)) begin
         n_err++; $display("FAIL short_line_errcnt: got %0d want %0d", err_count, exp_errcnt(exp_err)); end
      drive_frame(0, VT, VSL, -1, HT, HSL);
      n_chk++; if (locked !== 1'b0) begin n_err++; $display("FAIL relock_early: got %0b want 0", locked); end
      drive_frame(0, VT, VSL, -1, HT, HSL);
      n_chk++; if (locked !== 1'b1) begin n_err++; $display("FAIL relock: got %0b want 1", locked); end
   endtask

   task automatic test_bad_hsync_width();
      int base_l;
      base_l = n_line;
      drive_frame(0, VT, VSL, 3, HT, HSL - 1);
      exp_err += 1;
      n_chk++; if (n_line != base_l + 1) begin n_err++; $display("FAIL hs_width_err: got %0d want 1", n_line - base_l); end
      n_chk++; if (locked !== 1'b0) begin n_err++; $display("FAIL hs_width_unlock: got %0b want 0", locked); end
      n_chk++; if (err_count !== exp_errcnt(exp_err)) begin
         n_err++; $display("FAIL hs_width_errcnt: got %0d want %0d", err_count, exp_errcnt(exp_err)); end
   endtask

   task automatic test_frame_vsync();
      int base_l, base_f;
      base_l = n_line; base_f = n_frame;
      drive_frame(0, VT - 1, VSL, -1, HT, HSL);
      drive_frame(0, VT, VSL + 1, -1, HT, HSL);
      drive_frame(0, VT, VSL, -1, HT, HSL);
      exp_err += 2;
      n_chk++; if (n_frame != base_f + 2 || n_line != base_l) begin
         n_err++; $display("FAIL frame_vs_err: got frame+%0d line+%0d want 2,0", n_frame - base_f, n_line - base_l); end
      n_chk++; if (err_count !== exp_errcnt(exp_err)) begin
         n_err++; $display("FAIL frame_vs_errcnt: got %0d want %0d", err_count, exp_errcnt(exp_err)); end
   endtask

   task automatic test_reset_midframe();
      int base_l, base_f;
      drive_frame(0, VT, VSL, -1, HT, HSL);
      drive_frame(0, VT, VSL, -1, HT, HSL);
      n_chk++; if (locked !== 1'b1) begin n_err++; $display("FAIL prereset_lock: got %0b want 1", locked); end
      drive_frame(0, 7, VSL, -1, HT, HSL);
      reset = 1'b1;
      drive_line(7, HT, HSL, 1'b0);
      n_chk++; if (locked !== 1'b0 || err_count !== 8'h00) begin
         n_err++; $display("FAIL midreset_state: got locked=%0b errcnt=%0d want 0,0", locked, err_count); end
      n_chk++; if (rx_hcount !== 10'd0 || rx_vcount !== 10'd0 || {line_err, frame_err, frame_start, rx_visible} !== 4'b0000) begin
         n_err++; $display("FAIL midreset_outputs: got %0d,%0d pulses=%b want 0,0 0000", rx_hcount, rx_vcount,
                           {line_err, frame_err, frame_start, rx_visible}); end
      reset = 1'b0;
      exp_err = 0;
      base_l = n_line; base_f = n_frame;
      drive_frame(8, VT, VSL, -1, HT, HSL);
      drive_frame(0, VT, VSL, -1, HT, HSL);
      n_chk++; if (n_line != base_l || n_frame != base_f) begin
         n_err++; $display("FAIL postreset_clean: got line+%0d frame+%0d want 0,0", n_line - base_l, n_frame - base_f); end
      n_chk++; if (locked !== 1'b0) begin n_err++; $display("FAIL postreset_locked: got %0b want 0", locked); end
   endtask

   task automatic test_saturation();
      int base_l;
      base_l = n_line;
      drive_frame(0, 6, VSL, -1, HT, HSL);
      for (int i = 0; i < 300; i++) drive_line(6, HT - 1, HSL, 1'b0);
      drive_line(7, HT, HSL, 1'b0);
      exp_err += 300;
      n_chk++; if (n_line != base_l + 300) begin n_err++; $display("FAIL sat_lines: got %0d want 300", n_line - base_l); end
      n_chk++; if (err_count !== exp_errcnt(exp_err)) begin
         n_err++; $display("FAIL sat_errcnt: got %0d want %0d", err_count, exp_errcnt(exp_err)); end
   endtask

   initial begin
      test_reset();
      test_nominal_lock();
      test_frame_start();
      test_short_line();
      test_bad_hsync_width();
      test_frame_vsync();
      test_reset_midframe();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side checker for the 640x480@60 VGA link driven by `vga_640x480`. It samples `hsync`/`vsync` on the pixel clock and rebuilds the pixel coordinates from the sync edges alone. It measures line, frame and sync-pulse lengths against the standard timing and reports lock and errors. It sits beside the VGA core in simulation and on-board debug builds, observing the same wires that leave the FPGA.

## Interface
- `H_TOTAL`, 800, pixel clocks per line
- `H_SYNC_START`, 656, hcount of hsync falling edge
- `H_SYNC_LEN`, 96, hsync low width in clocks
- `V_TOTAL`, 525, lines per frame
- `V_SYNC_START`, 490, vcount of vsync falling edge
- `V_SYNC_LEN`, 2, vsync low width in lines
- `LOCK_FRAMES`, 2, consecutive clean frames required to lock
- `clk  in  1`  pixel clock (25 MHz); the single clock of the block
- `reset  in  1`  synchronous, active-high reset
- `hsync  in  1`  active-low horizontal sync under test
- `vsync  in  1`  active-low vertical sync under test
- `locked  out  1`  timing lock achieved
- `rx_hcount  out  10`  reconstructed column, 0..H_TOTAL-1
- `rx_vcount  out  10`  reconstructed line, 0..V_TOTAL-1
- `rx_visible  out  1`  high when rx_hcount<640 and rx_vcount<480
- `frame_start  out  1`  one-cycle pulse when rx_hcount==0 and rx_vcount==0
- `line_err  out  1`  one-cycle pulse on a bad line length or bad hsync width
- `frame_err  out  1`  one-cycle pulse on a bad frame length or bad vsync width
- `err_count  out  8`  saturating count of error pulses

## Operation
- **Input stage.** `hsync` and `vsync` pass through two flops: `hs_q`/`vs_q`, then `hs_d`/`vs_d`. An hsync fall is `hs_d & ~hs_q`; a rise is `~hs_d & hs_q`. Vsync edges are decoded the same way.
- **Horizontal counter.**
  - Free-runs modulo H_TOTAL.
  - On an hsync fall it loads H_SYNC_START, so rx_hcount==H_SYNC_START in the cycle the fall is detected.
- **Vertical counter.**
  - Increments when rx_hcount wraps H_TOTAL-1→0, and wraps at V_TOTAL.
  - On a vsync fall it loads V_SYNC_START, taking priority over the increment.
- **Line length.** A 10-bit counter runs between hsync falls and saturates at 1023.
  - Any fall where the count ≠ H_TOTAL raises `line_err`.
  - The first fall after reset has no previous edge to measure against and is not checked.
- **Hsync width.** The width counter counts cycles while `hs_q` is low. On a rise, a width ≠ H_SYNC_LEN raises `line_err`.
- **Frame length.** A lines-between-vsync-falls counter uses the same rule as line length, against V_TOTAL, and raises `frame_err`.
- **Vsync width.** Checked in hsync falls while `vs_q` is low, against V_SYNC_LEN; a mismatch raises `frame_err`.
- **Lock FSM.**
  - SEARCH: waits for the first vsync fall, then goes to TRACK with good_cnt=0.
  - TRACK: each error-free frame (vsync fall to vsync fall) increments good_cnt. Any error resets good_cnt to 0. Reaching LOCK_FRAMES goes to LOCKED.
  - LOCKED: `locked`=1. Any `line_err` or `frame_err` returns to SEARCH, and `locked` deasserts the next cycle.
- Coordinate outputs run in every state; they are only meaningful while `locked`=1.

## Timing
- **Latency.** The monitor sees a sync edge 2 clocks after the pin changes.
  - While `locked`=1, rx_hcount/rx_vcount equal the source hcount/vcount delayed by 2 clocks.
  - `rx_visible` and `frame_start` are registered, aligned with rx_hcount/rx_vcount.
- **Error pulses.** `line_err` and `frame_err` pulse high for exactly one cycle, in the edge-detect cycle.
- **Simultaneous events.**
  - When a line error and a frame error occur in the same cycle, both pulse and `err_count` increments by 2, saturating at 255.
  - A vsync fall coinciding with an hsync fall applies both loads.
- **Reset values**, one cycle after `reset`:
  - all counters 0; FSM in SEARCH; `locked`=0; all pulses 0; `err_count`=0.
  - Edge flops load 1 (idle-high sync), so no false edge appears after reset.
- **Reset mid-frame** discards all history; the first edges after reset are treated as unchecked.

## Configuration
- `VGA_SYNC_MON_ERRCNT_EN`:
  - Defined: `err_count` is implemented as above.
  - Undefined: `err_count` is tied to 8'h00 and the counter logic is omitted.
  - `line_err`, `frame_err` and `locked` behave identically in both builds.

## Test plan
- **Nominal lock.** Drive from `vga_640x480` for 4 frames → `locked`=1 after the 3rd vsync fall; `err_count`=0; rx_hcount = source hcount delayed 2 clocks.
- **Frame start.** Nominal stream → `frame_start` pulses once per 420000 clocks, with rx_hcount=0 and rx_vcount=0.
- **Short line.** Locked, then one line of 799 clocks → one `line_err` pulse; `locked` drops the next cycle; relock after 2 clean frames.
- **Bad hsync width.** One hsync pulse of 95 clocks → `line_err` on its rising edge; `err_count`=1.
- **Frame and vsync width.** Frame of 524 lines → `frame_err`; vsync held low for 3 lines → `frame_err`; `err_count`=2.
- **Reset and saturation.** Reset asserted mid-frame while locked → all outputs return to their reset values; no error reported on the first edges afterwards. Then 300 bad lines → `err_count` saturates at 255.
